ins_fetch_ctrl: RTL and testbench

Instruction fetch sequencer between the PC/control unit and the 512×8 instruction RAM. It drives the IRAM byte address and gathers a variable-length instruction: one opcode byte plus 0–2 operand bytes. The assembled instruction is presented to the control unit over a valid/ready handshake. Jumps redirect the fetch stream at any time.

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ins_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_ins_fetch_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Define IFETCH_BOUNDS_EN to compile the STOP state used for PC overflow faults.
package ifetch_pkg;

  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_DATA_W   = 8;
  localparam int MAX_OPERANDS = 2;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_A,
    FETCH_B,
    HOLD
`ifdef IFETCH_BOUNDS_EN
    , STOP
`endif
  } state_t;

endpackage

// File: rtl/ins_fetch_ctrl.sv
// Gathers opcode + 0..2 operand bytes from IRAM and offers them over valid/ready.
// IFETCH_BOUNDS_EN: PC increment past the top of IRAM faults into STOP instead of wrapping.
module ins_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          DATA_W   = DEF_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic [DATA_W-1:0] ins_data,
  input  logic [1:0]        ins_len,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] ins_opcode,
  output logic [DATA_W-1:0] ins_op1,
  output logic [DATA_W-1:0] ins_op2,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              fault
);

  localparam logic [1:0] MAX_N = 2'(MAX_OPERANDS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic [1:0]        n, len_c;
  logic              cap_op, cap_a, cap_b, inc;

  assign len_c     = (ins_len > MAX_N) ? MAX_N : ins_len;
  assign ins_addr  = pc;
  assign ins_valid = (state == HOLD);

`ifdef IFETCH_BOUNDS_EN
  logic pc_wrap, fault_q, fault_nxt;
  assign {pc_wrap, pc_inc} = {1'b0, pc} + (ADDR_W + 1)'(1);
  assign fault = fault_q;
`else
  assign pc_inc = pc + ADDR_W'(1);
  assign fault  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap_op    = 1'b0;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    inc       = 1'b0;
`ifdef IFETCH_BOUNDS_EN
    fault_nxt = fault_q;
`endif
    unique case (state)
      FETCH_OP: if (fetch_en) begin
        cap_op    = 1'b1;
        inc       = 1'b1;
        state_nxt = (len_c != 2'd0) ? FETCH_A : HOLD;
      end
      FETCH_A: begin
        cap_a     = 1'b1;
        inc       = 1'b1;
        state_nxt = (n == 2'd2) ? FETCH_B : HOLD;
      end
      FETCH_B: begin
        cap_b     = 1'b1;
        inc       = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (ins_ready) state_nxt = FETCH_OP;
`ifdef IFETCH_BOUNDS_EN
      STOP: state_nxt = STOP;
`endif
      default: state_nxt = FETCH_OP;
    endcase
    if (inc) pc_nxt = pc_inc;
`ifdef IFETCH_BOUNDS_EN
    // Overflowing fetch is abandoned entirely: no capture, PC frozen at the top.
    if (inc && pc_wrap) begin
      pc_nxt    = pc;
      state_nxt = STOP;
      fault_nxt = 1'b1;
      cap_op    = 1'b0;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
    end
`endif
    // A jump overrides everything, including a capture in the same cycle.
    if (jmp_en) begin
      pc_nxt    = jmp_addr;
      state_nxt = FETCH_OP;
      cap_op    = 1'b0;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
`ifdef IFETCH_BOUNDS_EN
      fault_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_OP;
      pc         <= ADDR_W'(RESET_PC);
      n          <= 2'd0;
      ins_opcode <= '0;
      ins_op1    <= '0;
      ins_op2    <= '0;
`ifdef IFETCH_BOUNDS_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
`ifdef IFETCH_BOUNDS_EN
      fault_q <= fault_nxt;
`endif
      if (cap_op) begin
        ins_opcode <= ins_data;
        ins_op1    <= '0;
        ins_op2    <= '0;
        n          <= len_c;
      end
      if (cap_a) ins_op1 <= ins_data;
      if (cap_b) ins_op2 <= ins_data;
    end
  end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl with a 512x8 IRAM model and opcode-length decoder table.
module tb_ins_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] ins_addr;
  logic [7:0] ins_data;
  logic [1:0] ins_len;
  logic       fetch_en;
  logic [7:0] ins_opcode, ins_op1, ins_op2;
  logic       ins_valid;
  logic       ins_ready;
  logic       jmp_en;
  logic [8:0] jmp_addr;
  logic       fault;

  logic [7:0] mem    [512];
  logic [1:0] lenmap [256];
  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  assign ins_data = mem[ins_addr];
  assign ins_len  = lenmap[ins_data];

  ins_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ins_addr  (ins_addr),
    .ins_data  (ins_data),
    .ins_len   (ins_len),
    .fetch_en  (fetch_en),
    .ins_opcode(ins_opcode),
    .ins_op1   (ins_op1),
    .ins_op2   (ins_op2),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .fault     (fault)
  );

  // Inputs change just after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk) if (!rst && ins_valid && ins_ready) xfers++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;
    for (int i = 0; i < 256; i++) lenmap[i] = 2'd0;
    lenmap[54] = 2'd2; lenmap[90] = 2'd2; lenmap[38] = 2'd1; lenmap[2] = 2'd0;
    mem[0] = 54; mem[1] = 11; mem[2] = 12;
    mem[3] = 90; mem[4] = 21; mem[5] = 22;
    mem[82] = 38; mem[83] = 55;
    mem[99] = 2; mem[100] = 2;
    mem[510] = 90; mem[511] = 66;

    rst = 1'b1; fetch_en = 1'b0; ins_ready = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
    #12;
    check("rst_addr", 32'(ins_addr), 0);
    check("rst_valid", 32'(ins_valid), 0);
    check("rst_opcode", 32'(ins_opcode), 0);
    check("rst_op1", 32'(ins_op1), 0);
    check("rst_op2", 32'(ins_op2), 0);
    check("rst_fault", 32'(fault), 0);
    rst = 1'b0;

    step(); step();
    check("fetch_dis_addr", 32'(ins_addr), 0);
    check("fetch_dis_valid", 32'(ins_valid), 0);

    fetch_en = 1'b1;
    step();
    check("i1_e1_opcode", 32'(ins_opcode), 54);
    check("i1_e1_addr", 32'(ins_addr), 1);
    step();
    check("i1_e2_valid", 32'(ins_valid), 0);
    step();
    check("i1_valid", 32'(ins_valid), 1);
    check("i1_opcode", 32'(ins_opcode), 54);
    check("i1_op1", 32'(ins_op1), 11);
    check("i1_op2", 32'(ins_op2), 12);
    check("i1_addr", 32'(ins_addr), 3);

    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_valid", 32'(ins_valid), 1);
      check("stall_opcode", 32'(ins_opcode), 54);
      check("stall_op2", 32'(ins_op2), 12);
      check("stall_addr", 32'(ins_addr), 3);
    end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    check("hs_valid_drop", 32'(ins_valid), 0);
    check("hs_xfers", 32'(xfers), 1);

    step();
    check("part_opcode", 32'(ins_opcode), 90);
    check("part_op1_clr", 32'(ins_op1), 0);
    check("part_addr", 32'(ins_addr), 4);
    jmp_en = 1'b1; jmp_addr = 9'd82;
    step();
    jmp_en = 1'b0;
    check("jmpA_valid", 32'(ins_valid), 0);
    check("jmpA_addr", 32'(ins_addr), 82);
    check("jmpA_op1", 32'(ins_op1), 0);
    step();
    check("j82_opcode", 32'(ins_opcode), 38);
    check("j82_addr", 32'(ins_addr), 83);
    step();
    check("j82_valid", 32'(ins_valid), 1);
    check("j82_op1", 32'(ins_op1), 55);
    check("j82_op2", 32'(ins_op2), 0);
    check("j82_next", 32'(ins_addr), 84);

    ins_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 9'd99;
    step();
    jmp_en = 1'b0;
    check("jmpH_valid", 32'(ins_valid), 0);
    check("jmpH_addr", 32'(ins_addr), 99);
    check("jmpH_xfers", 32'(xfers), 2);
    step();
    check("z_valid", 32'(ins_valid), 1);
    check("z_opcode", 32'(ins_opcode), 2);
    check("z_op1", 32'(ins_op1), 0);
    check("z_op2", 32'(ins_op2), 0);
    check("z_addr", 32'(ins_addr), 100);
    step();
    check("z_drop", 32'(ins_valid), 0);
    check("z_xfers", 32'(xfers), 3);
    step();
    check("z2_valid", 32'(ins_valid), 1);
    check("z2_addr", 32'(ins_addr), 101);
    ins_ready = 1'b0;

    jmp_en = 1'b1; jmp_addr = 9'd510;
    step();
    jmp_en = 1'b0;
    check("top_addr", 32'(ins_addr), 510);
    check("top_xfers", 32'(xfers), 3);
    step();
    check("top_opcode", 32'(ins_opcode), 90);
    check("top_addr1", 32'(ins_addr), 511);
    step();
`ifdef IFETCH_BOUNDS_EN
    check("ovf_fault", 32'(fault), 1);
    check("ovf_addr", 32'(ins_addr), 511);
    check("ovf_valid", 32'(ins_valid), 0);
    step();
    check("stop_fault", 32'(fault), 1);
    check("stop_addr", 32'(ins_addr), 511);
    check("stop_valid", 32'(ins_valid), 0);
`else
    check("wrap_fault", 32'(fault), 0);
    check("wrap_addr", 32'(ins_addr), 0);
    check("wrap_op1", 32'(ins_op1), 66);
    step();
    check("wrap_valid", 32'(ins_valid), 1);
    check("wrap_op2", 32'(ins_op2), 54);
    check("wrap_pc", 32'(ins_addr), 1);
`endif
    jmp_en = 1'b1; jmp_addr = 9'd0;
    step();
    jmp_en = 1'b0;
    check("clr_fault", 32'(fault), 0);
    check("clr_addr", 32'(ins_addr), 0);
    check("clr_valid", 32'(ins_valid), 0);

    step();
    check("mid_opcode", 32'(ins_opcode), 54);
    check("mid_addr", 32'(ins_addr), 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_addr", 32'(ins_addr), 0);
    check("arst_opcode", 32'(ins_opcode), 0);
    check("arst_valid", 32'(ins_valid), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    check("resume_addr", 32'(ins_addr), 1);
    check("resume_opcode", 32'(ins_opcode), 54);
    step(); step();
    check("resume_valid", 32'(ins_valid), 1);
    check("resume_op2", 32'(ins_op2), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
